// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt source conditioner and the interrupt controller.
package irq_pkg;

    localparam int IRQ_NUM_SRC_DEFAULT     = 32;
    localparam int IRQ_SYNC_STAGES_DEFAULT = 2;

    // Request vector handed from the conditioner to the interrupt controller.
    typedef logic [IRQ_NUM_SRC_DEFAULT-1:0] irq_vec_t;

endpackage : irq_pkg

// File: rtl/irq_sync_bit.sv
// Multi-flop synchroniser for one asynchronous interrupt line.
// SYNC_STAGES must lie in 2..4; the chain reads zero throughout reset.
module irq_sync_bit
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = IRQ_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the raw line through the chain; the last stage is the safe copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule : irq_sync_bit

// File: rtl/irq_source_conditioner.sv
// Turns raw peripheral interrupt lines into the registered request vector
// for the interrupt controller: synchronise, detect level/rising edge,
// latch pending, track overrun, mask and register.
module irq_source_conditioner
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = IRQ_NUM_SRC_DEFAULT,
    parameter int SYNC_STAGES = IRQ_SYNC_STAGES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_raw,
    input  logic [NUM_SRC-1:0] cfg_edge,
    input  logic [NUM_SRC-1:0] mask_en,
    input  logic               clr_valid,
    input  logic [NUM_SRC-1:0] clr_vec,
    output logic [NUM_SRC-1:0] interrupt_req,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overrun,
    output logic               irq_any
);

    logic [NUM_SRC-1:0] w_s;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pend_next;
    logic [NUM_SRC-1:0] w_ovr_next;
    logic [NUM_SRC-1:0] w_req_next;

    logic [NUM_SRC-1:0] r_s_d;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_ovr;
    logic [NUM_SRC-1:0] r_req;
    logic               r_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_sync
            irq_sync_bit #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk    (clk),
                .reset_n(reset_n),
                .i_async(irq_raw[gi]),
                .o_sync (w_s[gi])
            );
        end
    endgenerate

    // A rise is seen for exactly one cycle because s_d trails s by one flop.
    assign w_rise = w_s & ~r_s_d;
    assign w_clr  = clr_valid ? clr_vec : '0;

    // Edge sources: a rise always sets (so set beats clear), otherwise a
    // clear drops the bit, otherwise hold. Level sources just follow s.
    assign w_pend_next = (cfg_edge & (w_rise | (r_pend & ~w_clr)))
                       | (~cfg_edge & w_s);

    // Edge sources: a clear wins over everything, even a coincident rise;
    // a rise onto an already pending bit flags overrun. Level sources hold.
    assign w_ovr_next = (cfg_edge & ~w_clr & (r_ovr | (w_rise & r_pend)))
                      | (~cfg_edge & r_ovr);

    // Masking uses the registered pending, so unmasking takes one cycle.
    assign w_req_next = r_pend & mask_en;

    // All per-source state and the registered outputs advance together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s_d  <= '0;
            r_pend <= '0;
            r_ovr  <= '0;
            r_req  <= '0;
            r_any  <= 1'b0;
        end else begin
            r_s_d  <= w_s;
            r_pend <= w_pend_next;
            r_ovr  <= w_ovr_next;
            r_req  <= w_req_next;
            r_any  <= |w_req_next;
        end
    end

    assign interrupt_req = r_req;
    assign pending       = r_pend;
    assign overrun       = r_ovr;
    assign irq_any       = r_any;

endmodule : irq_source_conditioner

// File: tb/tb_irq_source_conditioner.sv
// Directed self-checking bench for irq_source_conditioner (32 sources, 2-stage sync).
module tb_irq_source_conditioner;
    import irq_pkg::*;

    logic     clk;
    logic     reset_n;
    irq_vec_t irq_raw;
    irq_vec_t cfg_edge;
    irq_vec_t mask_en;
    logic     clr_valid;
    irq_vec_t clr_vec;
    irq_vec_t interrupt_req;
    irq_vec_t pending;
    irq_vec_t overrun;
    logic     irq_any;

    int assertCount;
    int failCount;

    irq_source_conditioner #(
        .NUM_SRC    (IRQ_NUM_SRC_DEFAULT),
        .SYNC_STAGES(IRQ_SYNC_STAGES_DEFAULT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .irq_raw      (irq_raw),
        .cfg_edge     (cfg_edge),
        .mask_en      (mask_en),
        .clr_valid    (clr_valid),
        .clr_vec      (clr_vec),
        .interrupt_req(interrupt_req),
        .pending      (pending),
        .overrun      (overrun),
        .irq_any      (irq_any)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge, where inputs change and outputs are read.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input irq_vec_t raw, input logic cv, input irq_vec_t cvec);
        irq_raw   = raw;
        clr_valid = cv;
        clr_vec   = cvec;
    endtask

    task automatic checkOutput(input string tag, input irq_vec_t obs, input irq_vec_t exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;

        // Reset with every raw line held high.
        reset_n  = 1'b0;
        cfg_edge = '1;
        mask_en  = '1;
        applyStimulus('1, 1'b0, '0);
        tick(3);
        checkOutput("rst_req", interrupt_req, '0);
        checkOutput("rst_pend", pending, '0);
        checkOutput("rst_ovr", overrun, '0);
        checkOutput("rst_any", irq_type(irq_any), '0);

        // Release: request lands three edges after the first sampling edge.
        reset_n = 1'b1;
        tick(3);
        checkOutput("exit_req_early", interrupt_req, '0);
        checkOutput("exit_pend", pending, 32'hFFFF_FFFF);
        tick(1);
        checkOutput("exit_req", interrupt_req, 32'hFFFF_FFFF);
        checkOutput("exit_any", irq_type(irq_any), 32'h1);

        // Drop all lines and clear every pending bit.
        applyStimulus('0, 1'b1, '1);
        tick(1);
        applyStimulus('0, 1'b0, '0);
        tick(4);
        checkOutput("clrall_pend", pending, '0);
        checkOutput("clrall_req", interrupt_req, '0);
        checkOutput("clrall_ovr", overrun, '0);

        // Source 5: two-cycle pulse latches and holds after the pulse ends.
        applyStimulus(32'h20, 1'b0, '0);
        tick(2);
        applyStimulus('0, 1'b0, '0);
        checkOutput("s5_req_early", interrupt_req, '0);
        tick(1);
        checkOutput("s5_pend", pending, 32'h20);
        tick(1);
        checkOutput("s5_req", interrupt_req, 32'h20);
        tick(3);
        checkOutput("s5_req_hold", interrupt_req, 32'h20);

        // Clear source 5: pending drops first, request one cycle later.
        applyStimulus('0, 1'b1, 32'h20);
        tick(1);
        applyStimulus('0, 1'b0, '0);
        checkOutput("s5_clr_pend", pending, '0);
        checkOutput("s5_clr_req_lag", interrupt_req, 32'h20);
        tick(1);
        checkOutput("s5_clr_req", interrupt_req, '0);
        checkOutput("s5_clr_any", irq_type(irq_any), '0);

        // Overrun on source 5: two edges with no clear in between.
        applyStimulus(32'h20, 1'b0, '0);
        tick(2);
        applyStimulus('0, 1'b0, '0);
        tick(3);
        checkOutput("ovr_first_only", overrun, '0);
        applyStimulus(32'h20, 1'b0, '0);
        tick(2);
        applyStimulus('0, 1'b0, '0);
        tick(4);
        checkOutput("ovr_set", overrun, 32'h20);
        checkOutput("ovr_pend", pending, 32'h20);
        applyStimulus('0, 1'b1, 32'h20);
        tick(1);
        applyStimulus('0, 1'b0, '0);
        checkOutput("ovr_clr_pend", pending, '0);
        checkOutput("ovr_clr_ovr", overrun, '0);

        // Set beats clear on bit 3 while it is already pending.
        applyStimulus(32'h08, 1'b0, '0);
        tick(2);
        applyStimulus('0, 1'b0, '0);
        tick(3);
        checkOutput("sbc_pre_pend", pending, 32'h08);
        applyStimulus(32'h08, 1'b0, '0);
        tick(2);
        applyStimulus(32'h08, 1'b1, 32'h08);
        tick(1);
        applyStimulus(32'h08, 1'b0, '0);
        checkOutput("sbc_pend", pending, 32'h08);
        checkOutput("sbc_ovr", overrun, '0);
        applyStimulus('0, 1'b0, '0);
        tick(3);
        applyStimulus('0, 1'b1, 32'h08);
        tick(1);
        applyStimulus('0, 1'b0, '0);
        tick(2);
        checkOutput("sbc_cleanup", pending, '0);

        // Level mode and mask on source 0.
        cfg_edge = 32'hFFFF_FFFE;
        mask_en  = 32'hFFFF_FFFE;
        applyStimulus(32'h01, 1'b0, '0);
        tick(3);
        checkOutput("lvl_pend", pending, 32'h01);
        tick(1);
        checkOutput("lvl_masked_req", interrupt_req, '0);
        mask_en = '1;
        tick(1);
        checkOutput("lvl_unmask_req", interrupt_req, 32'h01);
        checkOutput("lvl_unmask_any", irq_type(irq_any), 32'h1);
        applyStimulus(32'h01, 1'b1, 32'h01);
        tick(1);
        applyStimulus(32'h01, 1'b0, '0);
        checkOutput("lvl_clr_noeffect", pending, 32'h01);
        applyStimulus('0, 1'b0, '0);
        tick(3);
        checkOutput("lvl_fall_pend", pending, '0);
        checkOutput("lvl_fall_req_lag", interrupt_req, 32'h01);
        tick(1);
        checkOutput("lvl_fall_req", interrupt_req, '0);

        // Build pending and overrun state, then reset asynchronously mid-cycle.
        cfg_edge = '1;
        applyStimulus(32'hA5A5_A5A5, 1'b0, '0);
        tick(2);
        applyStimulus('0, 1'b0, '0);
        tick(3);
        applyStimulus(32'hA5A5_A5A5, 1'b0, '0);
        tick(2);
        applyStimulus('0, 1'b0, '0);
        tick(3);
        checkOutput("mid_pend", pending, 32'hA5A5_A5A5);
        checkOutput("mid_ovr", overrun, 32'hA5A5_A5A5);
        checkOutput("mid_req", interrupt_req, 32'hA5A5_A5A5);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_req", interrupt_req, '0);
        checkOutput("arst_pend", pending, '0);
        checkOutput("arst_ovr", overrun, '0);
        checkOutput("arst_any", irq_type(irq_any), '0);
        tick(1);
        reset_n = 1'b1;
        tick(4);
        checkOutput("post_rst_pend", pending, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Widen a single-bit output so it can go through the common vector check.
    function automatic irq_vec_t irq_type(input logic b);
        irq_vec_t v;
        v    = '0;
        v[0] = b;
        if (b === 1'bx || b === 1'bz) v = 'x;
        return v;
    endfunction

endmodule : tb_irq_source_conditioner

// File: doc/irq_source_conditioner.md
# irq_source_conditioner

Conditions raw peripheral interrupt lines (camera, DMA, timers, codec) into the registered 32-bit request vector consumed by the interrupt controller's `interrupt_req` input. Each source is synchronised, configured as level or rising-edge, latched into a pending bit, masked, and driven out as a registered request. Edge sources stay pending until software clears them and record an overrun when a second edge arrives while still pending.

## Interface

Parameters:
- `NUM_SRC`, 32: number of interrupt sources; also the width of every vector port.
- `SYNC_STAGES`, 2: synchroniser depth, legal range 2..4.

Ports:
- `clk`  in  1  single system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `irq_raw`  in  NUM_SRC  asynchronous source lines, active high.
- `cfg_edge`  in  NUM_SRC  per source: 1 = rising-edge sticky, 0 = level.
- `mask_en`  in  NUM_SRC  per source: 1 = forward to request output.
- `clr_valid`  in  1  one-cycle strobe that applies `clr_vec`; always accepted, no ready.
- `clr_vec`  in  NUM_SRC  write-1-to-clear for pending and overrun bits of edge sources.
- `interrupt_req`  out  NUM_SRC  registered `pending & mask_en`; feeds the interrupt controller.
- `pending`  out  NUM_SRC  unmasked pending state, for status readback.
- `overrun`  out  NUM_SRC  sticky: an edge arrived while that source was already pending.
- `irq_any`  out  1  registered OR of `interrupt_req`.

## Operation

- Per source: `SYNC_STAGES`-flop synchroniser to `s`, then a one-flop delayed copy `s_d`. Rise = `s & ~s_d`.
- Level mode (`cfg_edge`=0):
  - `pending` <= `s` every cycle.
  - `clr_vec` has no effect.
  - `overrun` holds its value.
- Edge mode (`cfg_edge`=1), next value per bit:
  - rise: `pending` <= 1. If `pending` was already 1 and that bit is not being cleared this cycle, `overrun` <= 1.
  - otherwise, `clr_valid & clr_vec[i]`: `pending` <= 0 and `overrun` <= 0.
  - otherwise: hold.
- Simultaneous rise and clear on the same bit: set wins, so `pending` stays 1 and no edge is lost. `overrun` is cleared, not set.
- Mode switch: `pending` keeps its current value. Level to edge leaves a 1 latched until it is cleared.
- `interrupt_req` <= `pending & mask_en`, where `pending` is the registered value.
- `irq_any` <= OR-reduce of the next `interrupt_req`, so it is coincident with `interrupt_req`.
- A masked pending bit is retained. Unmasking later raises the request one cycle after `mask_en` rises.
- No arithmetic. All vectors are `NUM_SRC` wide, bitwise, with no cross-bit interaction except `irq_any`.

## Timing

- Reset (async assert, synchronous deassert handled upstream) forces all of the following to 0:
  - synchroniser flops and `s_d`
  - `pending`, `overrun`, `interrupt_req`, `irq_any`
- A source held high through reset exit produces exactly one rising edge once the synchronizer fills.
- Latency, with `irq_raw` rising and sampled at edge N:
  - `s` = 1 after edge N+SYNC_STAGES-1
  - `pending` = 1 after edge N+SYNC_STAGES
  - `interrupt_req`/`irq_any` = 1 after edge N+SYNC_STAGES+1
  - For `SYNC_STAGES`=2 this is 3 cycles.
- Clear latency: `clr_valid` at edge M drops `pending` after M and `interrupt_req` after M+1.
- Pulse width: a raw pulse must be held for at least 2 clock cycles to guarantee capture. Shorter pulses may be missed, and that is not an error.
- Reset mid-operation discards all pending and overrun state immediately. No clear is needed afterwards.

## Structure

- Package `irq_pkg`:
  - `IRQ_NUM_SRC_DEFAULT` = 32
  - `IRQ_SYNC_STAGES_DEFAULT` = 2
  - typedef `irq_vec_t` (32-bit vector), shared with the interrupt controller.
- Sub-module `irq_sync_bit`: parameterised `SYNC_STAGES` flop chain with async active-low reset. Instantiated `NUM_SRC` times in a generate loop.
- Top level holds the per-bit edge detect, pending/overrun logic and output registers.

## Test plan

- Reset: with `irq_raw`=0xFFFF_FFFF during reset, every output is 0 while `reset_n`=0. After release, with `cfg_edge`=all-1 and `mask_en`=all-1, `interrupt_req`=0xFFFF_FFFF at exactly cycle 3 and `irq_any`=1.
- Edge latch/clear on source 5:
  - Pulse `irq_raw[5]` for 2 cycles: `interrupt_req`=0x0000_0020 3 cycles later, and it holds after the pulse ends.
  - `clr_valid` with `clr_vec`=0x20: `pending`=0 the next cycle and `interrupt_req`=0 one cycle after that.
- Overrun on source 5: two separated edges with no clear in between give `overrun[5]`=1. A clear with `clr_vec`=0x20 returns both `pending[5]` and `overrun[5]` to 0.
- Set beats clear: arrange a rise on bit 3 in the same cycle as a clear of 0x08. Result: `pending[3]`=1 and `overrun[3]`=0.
- Level and mask on source 0 (`cfg_edge[0]`=0, `mask_en[0]`=0):
  - `irq_raw[0]` high: `pending[0]`=1 and `interrupt_req[0]`=0.
  - Set `mask_en[0]`=1: request appears the next cycle.
  - Drop `irq_raw[0]`: request falls 3 cycles later. A clear has no effect.
- Mid-operation reset: with `pending`=0xA5A5_A5A5 and `overrun`≠0, assert `reset_n`=0 asynchronously between edges. All outputs read 0 before the next clock edge.
